// File: rtl/frame_config_pkg.sv
// Shared constants and types for the column configuration-frame loader:
// sync word, header opcodes, header field positions and loader states.
package frame_config_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_DESYNC = 4'h2;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int IDX_MSB = 12;
    localparam int IDX_LSB = 8;
    localparam int CNT_MSB = 7;
    localparam int CNT_LSB = 0;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
    localparam int CNT_W   = CNT_MSB - CNT_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNCED,
        ST_DATA,
        ST_STROBE
    } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered frame-index to one-hot strobe decoder; all bits low unless enabled,
// so at most one strobe line can ever be high.
module frame_strobe_decoder
    import frame_config_pkg::*;
#(
    parameter int Width = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [Width-1:0] strobe_o
);

    genvar gi;
    for (gi = 0; gi < Width; gi++) begin : g_bit
        logic strobe_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                strobe_q <= 1'b0;
            end else begin
                strobe_q <= en_i && (idx_i == IDX_W'(gi));
            end
        end
        assign strobe_o[gi] = strobe_q;
    end

endmodule

// File: rtl/frame_config_loader.sv
// Column configuration writer: finds the sync word, parses frame-write headers,
// fills FrameData row by row and pulses one FrameStrobe bit per completed frame.
module frame_config_loader
    import frame_config_pkg::*;
#(
    parameter int NumRows         = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                WriteData,
    input  logic                       WriteStrobe,
    output logic                       WriteReady,
    output logic [32*NumRows-1:0]      FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Synced,
    output logic                       Error,
    output logic [15:0]                FrameCount
);

    localparam int RowW = $clog2(NumRows + 1);

    state_e            state_q;
    logic              ready_q;
    logic              synced_q;
    logic              error_q;
    logic [15:0]       count_q;
    logic [15:0]       count_d;
    logic [IDX_W-1:0]  idx_q;
    logic [RowW-1:0]   words_q;
    logic [RowW-1:0]   row_q;

    logic              xfer;
    logic [3:0]        hdr_op;
    logic [IDX_W-1:0]  hdr_idx;
    logic [CNT_W-1:0]  hdr_cnt;
    logic              hdr_ok;
    logic              data_wr;
    logic              frame_done;

    assign xfer    = WriteStrobe && ready_q;
    assign hdr_op  = WriteData[OP_MSB:OP_LSB];
    assign hdr_idx = WriteData[IDX_MSB:IDX_LSB];
    assign hdr_cnt = WriteData[CNT_MSB:CNT_LSB];
    assign hdr_ok  = (hdr_op == OP_WRITE)
                  && ({1'b0, hdr_idx} < (IDX_W + 1)'(MaxFramesPerCol))
                  && (hdr_cnt != '0)
                  && (hdr_cnt <= CNT_W'(NumRows));

    assign data_wr    = xfer && (state_q == ST_DATA);
    assign frame_done = data_wr && (row_q == words_q - RowW'(1));
    assign count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            synced_q <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
            idx_q    <= '0;
            words_q  <= '0;
            row_q    <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (xfer && WriteData == SYNC_WORD) begin
                        error_q  <= 1'b0;
                        synced_q <= 1'b1;
                        state_q  <= ST_SYNCED;
                    end
                end
                ST_SYNCED: begin
                    // A repeated sync word is checked first: its opcode nibble would otherwise read as an error.
                    if (xfer && WriteData != SYNC_WORD) begin
                        if (hdr_ok) begin
                            idx_q   <= hdr_idx;
                            words_q <= hdr_cnt[RowW-1:0];
                            row_q   <= '0;
                            state_q <= ST_DATA;
                        end else if (hdr_op == OP_DESYNC) begin
                            synced_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            error_q  <= 1'b1;
                            synced_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_wr) begin
                        row_q <= row_q + RowW'(1);
                    end
                    if (frame_done) begin
                        ready_q <= 1'b0;
                        count_q <= count_d;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state_q <= ST_SYNCED;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    for (gi = 0; gi < NumRows; gi++) begin : g_row
        logic [31:0] row_data_q;
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                row_data_q <= '0;
            end else if (data_wr && row_q == RowW'(gi)) begin
                row_data_q <= WriteData;
            end
        end
        assign FrameData[gi*32 +: 32] = row_data_q;
    end

    frame_strobe_decoder #(
        .Width (MaxFramesPerCol)
    ) u_strobe (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .en_i     (frame_done),
        .idx_i    (idx_q),
        .strobe_o (FrameStrobe)
    );

    assign WriteReady = ready_q;
    assign Synced     = synced_q;
    assign Error      = error_q;
    assign FrameCount = count_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader: a word-level reference model predicts
// frame image, status flags and strobes; a negedge monitor compares the DUT.
module tb_frame_config_loader;

    localparam int NR = 8;
    localparam int MF = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [31:0]     WriteData = '0;
    logic            WriteStrobe = 1'b0;
    logic            WriteReady;
    logic [32*NR-1:0] FrameData;
    logic [MF-1:0]   FrameStrobe;
    logic            Synced;
    logic            Error;
    logic [15:0]     FrameCount;

    always #5 CLK = ~CLK;

    frame_config_loader #(.NumRows(NR), .MaxFramesPerCol(MF)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .WriteReady  (WriteReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Synced      (Synced),
        .Error       (Error),
        .FrameCount  (FrameCount)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the stream seen as words, a frame image and a pending-word count.
    typedef struct {
        int             idx;
        logic [255:0]   data;
        int             frames;
    } exp_t;

    exp_t        sbq[$];
    bit          m_synced = 0;
    bit          m_error = 0;
    int          m_remaining = 0;
    int          m_row = 0;
    int          m_idx = 0;
    int          m_frames = 0;
    logic [31:0] m_img[NR];

    function automatic logic [255:0] img_flat();
        logic [255:0] r = '0;
        for (int k = 0; k < NR; k++) r[k*32 +: 32] = m_img[k];
        return r;
    endfunction

    task automatic model_reset();
        m_synced = 0; m_error = 0; m_remaining = 0; m_row = 0; m_idx = 0; m_frames = 0;
        for (int k = 0; k < NR; k++) m_img[k] = '0;
        sbq.delete();
    endtask

    task automatic model_accept(input logic [31:0] w);
        int op, idx, n;
        exp_t e;
        op = int'(w[31:28]); idx = int'(w[12:8]); n = int'(w[7:0]);
        if (!m_synced) begin
            if (w == SYNC) begin m_synced = 1; m_error = 0; end
        end else if (m_remaining > 0) begin
            m_img[m_row] = w;
            m_row++;
            m_remaining--;
            if (m_remaining == 0) begin
                if (m_frames < 65535) m_frames++;
                e.idx = m_idx; e.data = img_flat(); e.frames = m_frames;
                sbq.push_back(e);
            end
        end else if (w == SYNC) begin
            // ignored while synced between frames
        end else if (op == 1 && idx < MF && n >= 1 && n <= NR) begin
            m_remaining = n; m_row = 0; m_idx = idx;
        end else if (op == 2) begin
            m_synced = 0;
        end else begin
            m_error = 1; m_synced = 0;
        end
    endtask

    // Drivers act 1 time unit after the rising edge; the monitor samples on the falling edge.
    task automatic idle(input int n);
        WriteStrobe = 1'b0;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        bit ok;
        if (gap > 0) idle(gap);
        WriteStrobe = 1'b1;
        WriteData = w;
        for (int t = 0; ; t++) begin
            ok = WriteReady;
            @(posedge CLK);
            if (ok) break;
            if (t >= 20) begin
                checks++; failures++;
                $display("FAIL send_timeout word=%0h actual_ready=0 required_ready=1", w);
                #1;
                return;
            end
            #1;
        end
        model_accept(w);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        #1;
        check("rst_framedata", FrameData, '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_ready", WriteReady, 0);
        check("rst_synced", Synced, 0);
        check("rst_error", Error, 0);
        check("rst_count", FrameCount, 0);
        WriteStrobe = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(2);
    endtask

    int settle = 0;
    always @(negedge CLK) begin
        exp_t e;
        logic [MF-1:0] es;
        if (RESET) begin
            settle = 0;
        end else begin
            settle++;
            check("framedata", FrameData, img_flat());
            check("synced", Synced, m_synced);
            check("error", Error, m_error);
            check("framecount", FrameCount, m_frames);
            if (settle >= 2) check("ready", WriteReady, (FrameStrobe == '0));
            if (FrameStrobe != '0) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe actual=%0h required=0", FrameStrobe);
                end else begin
                    e = sbq.pop_front();
                    es = '0;
                    es[e.idx] = 1'b1;
                    check("strobe_bit", FrameStrobe, es);
                    check("strobe_data", FrameData, e.data);
                    check("strobe_count", FrameCount, e.frames);
                end
            end
        end
    end

    initial begin
        int kind, n;
        model_reset();
        @(posedge CLK); #1;
        do_reset();

        // header before sync is discarded
        send(32'h1000_0301, 0);
        idle(2);
        check("presync_synced", Synced, 0);
        send(SYNC, 1);
        idle(1);
        check("sync_synced", Synced, 1);

        // full frame idx 3
        send(32'h1000_0308, 0);
        for (int k = 1; k <= 8; k++) send(32'h1111_1111 * k, 0);
        idle(3);
        check("first_count", FrameCount, 1);

        // bad headers: index 25, count 0, opcode 7
        send(32'h1000_1908, 0); idle(1); check("bad_idx_error", Error, 1);
        send(SYNC, 0); idle(1); check("resync_error", Error, 0);
        send(32'h1000_0300, 0); idle(1); check("bad_cnt_error", Error, 1);
        send(SYNC, 0);
        send(32'h7000_0301, 0); idle(1); check("bad_op_error", Error, 1);
        send(SYNC, 0); idle(1); check("resync2_synced", Synced, 1);

        // partial frame idx 0 count 2 keeps rows 2..7
        send(32'h1000_0002, 0);
        send(32'hAAAA_0000, 0);
        send(32'hBBBB_0001, 0);
        idle(3);
        check("partial_row2", FrameData[95:64], 32'h3333_3333);

        // back-to-back frames with strobe held high
        n = m_frames;
        send(32'h1000_0503, 0);
        for (int k = 0; k < 3; k++) send($urandom, 0);
        send(SYNC, 0);
        send(32'h1000_0608, 0);
        for (int k = 0; k < 8; k++) send($urandom, 0);
        idle(3);
        check("b2b_count", FrameCount, n + 2);

        // reset mid-frame after 4 of 8 words
        send(32'h1000_0408, 0);
        for (int k = 0; k < 4; k++) send($urandom, 0);
        do_reset();
        send(32'h1000_0301, 0);
        idle(2);
        check("postrst_synced", Synced, 0);
        send(SYNC, 0);
        send(32'h2000_0000, 0);
        idle(1);
        check("desync_synced", Synced, 0);

        // reset while the strobe is high
        send(SYNC, 0);
        send(32'h1000_0701, 0);
        send(32'hDEAD_BEEF, 0);
        check("strobe_before_rst", FrameStrobe, 20'h0_0080);
        sbq.delete();
        do_reset();

        // randomized traffic
        send(SYNC, 0);
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 99);
            if (kind < 70) begin
                n = $urandom_range(1, NR);
                send({4'h1, 15'($urandom), 5'($urandom_range(0, MF-1)), 8'(n)}, $urandom_range(0, 2));
                for (int k = 0; k < n; k++) send($urandom, $urandom_range(0, 2));
            end else if (kind < 80) begin
                case ($urandom_range(0, 2))
                    0:       send({4'h1, 15'd0, 5'($urandom_range(MF, 31)), 8'($urandom_range(1, NR))}, 0);
                    1:       send({4'h1, 15'd0, 5'($urandom_range(0, MF-1)), 8'($urandom_range(NR+1, 255))}, 0);
                    default: send({4'($urandom_range(3, 15)), 28'($urandom)}, 0);
                endcase
            end else if (kind < 85) begin
                send(32'h2000_0000, $urandom_range(0, 2));
            end else if (kind < 90) begin
                send(SYNC, $urandom_range(0, 2));
            end else begin
                send($urandom, $urandom_range(0, 2));
            end
            if (!m_synced && m_remaining == 0 && $urandom_range(0, 1) == 1) send(SYNC, 0);
        end
        idle(5);
        check("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
